fft_job_ctrl: RTL and testbench

Parametrised job controller for the FFT accelerator. It replaces the single-request start/load/calc/unload sequencer. It arbitrates N_CH requesters round-robin and counts RAM words itself instead of waiting for external "done" strobes. It also adds an optional filter pass and a watchdog timeout. It sits between the host-side request interface, the input/output FIFOs, the sample RAM and the FFT datapath.

---
 rtl/fft_ctrl_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/fft_job_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fft_job_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared state encoding and round-robin pick helper for fft_job_ctrl
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC_START,
        S_CALC_WAIT,
        S_FILTER,
        S_UNLOAD,
        S_DONE
    } state_t;

    localparam int MAX_CH = 8;

    // First set bit of req at or after ptr, wrapping at n; -1 when nothing requests.
    function automatic int rr_pick(input logic [MAX_CH-1:0] req, input int ptr, input int n);
        int idx;
        rr_pick = -1;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (req[idx[2:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection from a rotating pointer
module rr_arbiter
    import fft_ctrl_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int CH_W = 1
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            grant_valid,
    output logic [CH_W-1:0] grant_idx
);

    logic [MAX_CH-1:0] req_ext;
    int                pick;

    always_comb begin
        req_ext = '0;
        req_ext[N_CH-1:0] = req;
        pick = rr_pick(req_ext, int'(ptr), N_CH);
        grant_valid = (pick >= 0);
        grant_idx = grant_valid ? pick[CH_W-1:0] : '0;
    end

endmodule

// File: rtl/fft_job_ctrl.sv
// rtl/fft_job_ctrl.sv - multi-channel FFT job sequencer: load, transform, optional filter, unload
module fft_job_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DEPTH       = 1024,
    parameter int TIMEOUT_CYC = 65535,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req_valid,
    input  logic [N_CH-1:0]   req_ifft,
    input  logic [N_CH-1:0]   req_filt,
    output logic [N_CH-1:0]   req_ready,
    input  logic              in_empty,
    output logic              in_pop,
    input  logic              out_full,
    output logic              out_push,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              calc_start,
    input  logic              calc_done,
    output logic              is_ifft,
    output logic              write_filter,
    output logic              busy,
    output logic              done_valid,
    output logic [CH_W-1:0]   done_ch,
    output logic              done_err
);

    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0]  LAST_WORD   = ADDR_W'(DEPTH - 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYC - 1);

    state_t              state, state_nx;
    logic [CH_W-1:0]     rr_ptr, rr_ptr_nx;
    logic [ADDR_W-1:0]   cnt, cnt_nx;
    logic [STALL_W-1:0]  stall, stall_nx;
    logic                err, err_nx;
    logic [CH_W-1:0]     ch, ch_nx;
    logic                ifft, ifft_nx;
    logic                filt, filt_nx;

    logic                grant_valid;
    logic [CH_W-1:0]     grant_idx;
    logic                stall_cyc;
    logic                timeout;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A wait state that made no progress this cycle feeds the watchdog.
    assign stall_cyc = ((state == S_LOAD) && in_empty) ||
                       ((state == S_CALC_WAIT) && !calc_done) ||
                       ((state == S_UNLOAD) && out_full);
    assign timeout   = stall_cyc && (stall == STALL_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            stall  <= '0;
            err    <= 1'b0;
            ch     <= '0;
            ifft   <= 1'b0;
            filt   <= 1'b0;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_ptr_nx;
            cnt    <= cnt_nx;
            stall  <= stall_nx;
            err    <= err_nx;
            ch     <= ch_nx;
            ifft   <= ifft_nx;
            filt   <= filt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        rr_ptr_nx    = rr_ptr;
        cnt_nx       = cnt;
        stall_nx     = stall_cyc ? stall + 1'b1 : '0;
        err_nx       = err;
        ch_nx        = ch;
        ifft_nx      = ifft;
        filt_nx      = filt;
        req_ready    = '0;
        in_pop       = 1'b0;
        out_push     = 1'b0;
        ram_addr     = '0;
        calc_start   = 1'b0;
        write_filter = 1'b0;
        done_valid   = 1'b0;
        done_ch      = '0;
        done_err     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    req_ready[grant_idx] = 1'b1;
                    ch_nx     = grant_idx;
                    ifft_nx   = req_ifft[grant_idx];
                    filt_nx   = req_filt[grant_idx];
                    rr_ptr_nx = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_nx    = '0;
                    stall_nx  = '0;
                    err_nx    = 1'b0;
                    state_nx  = S_LOAD;
                end
            end
            S_LOAD: begin
                in_pop   = !in_empty;
                ram_addr = cnt;
                if (!in_empty) begin
                    if (cnt == LAST_WORD) begin
                        cnt_nx   = '0;
                        state_nx = S_CALC_START;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else if (timeout) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_CALC_START: begin
                calc_start = 1'b1;
                state_nx   = S_CALC_WAIT;
            end
            S_CALC_WAIT: begin
                if (calc_done) begin
                    state_nx = filt ? S_FILTER : S_UNLOAD;
                end else if (timeout) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_FILTER: begin
                write_filter = 1'b1;
                ram_addr     = cnt;
                if (cnt == LAST_WORD) begin
                    cnt_nx   = '0;
                    state_nx = S_UNLOAD;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_UNLOAD: begin
                out_push = !out_full;
                ram_addr = cnt;
                if (!out_full) begin
                    if (cnt == LAST_WORD) begin
                        cnt_nx   = '0;
                        state_nx = S_DONE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else if (timeout) begin
                    err_nx   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                done_ch    = ch;
                done_err   = err;
                cnt_nx     = '0;
                ifft_nx    = 1'b0;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign is_ifft = ifft;

endmodule

// File: tb/tb_fft_job_ctrl.sv
// tb/tb_fft_job_ctrl.sv - table-driven and randomized job sessions checked against a job-level model
module tb_fft_job_ctrl;

    localparam int N_CH   = 2;
    localparam int DEPTH  = 8;
    localparam int TMO    = 16;
    localparam int ADDR_W = 3;
    localparam int CH_W   = 1;

    logic              clk;
    logic              rst;
    logic [N_CH-1:0]   req_valid;
    logic [N_CH-1:0]   req_ifft;
    logic [N_CH-1:0]   req_filt;
    logic [N_CH-1:0]   req_ready;
    logic              in_empty;
    logic              in_pop;
    logic              out_full;
    logic              out_push;
    logic [ADDR_W-1:0] ram_addr;
    logic              calc_start;
    logic              calc_done;
    logic              is_ifft;
    logic              write_filter;
    logic              busy;
    logic              done_valid;
    logic [CH_W-1:0]   done_ch;
    logic              done_err;
    logic [31:0]       out_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int model_ptr = 0;

    typedef struct {
        logic [1:0] mask;
        bit         cont;
        logic [1:0] ifft;
        logic [1:0] filt;
        int         lat;
        int         in_mode;
        int         out_mode;
        bit         noise;
        int         n_jobs;
        int         exp_first;
        bit         exp_err;
    } vec_t;

    fft_job_ctrl #(
        .N_CH        (N_CH),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ifft     (req_ifft),
        .req_filt     (req_filt),
        .req_ready    (req_ready),
        .in_empty     (in_empty),
        .in_pop       (in_pop),
        .out_full     (out_full),
        .out_push     (out_push),
        .ram_addr     (ram_addr),
        .calc_start   (calc_start),
        .calc_done    (calc_done),
        .is_ifft      (is_ifft),
        .write_filter (write_filter),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_ch      (done_ch),
        .done_err     (done_err)
    );

    assign out_vec = {18'b0, req_ready, in_pop, out_push, ram_addr, calc_start, is_ifft,
                      write_filter, busy, done_valid, done_ch, done_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [1:0] r, input int ptr);
        int c;
        for (int off = 0; off < N_CH; off++) begin
            c = (ptr + off) % N_CH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic run_session(input vec_t v, input int abort_at);
        logic [1:0] pend;
        int  cyc, jobs_done, g_cyc, cur_ch, g, exp_len, exp_filt, exp_push;
        int  pops, pushes, filts, addr_bad, ifft_bad, gap_in, gap_out, calc_cnt;
        int  sum_ig, sum_og, stray;
        int  ig[DEPTH+1];
        int  og[DEPTH+1];
        bit  e_ifft, e_filt, active, after_done, fin, first;

        pend = v.mask;
        cyc = 0; jobs_done = 0; g_cyc = 0; cur_ch = 0;
        pops = 0; pushes = 0; filts = 0; addr_bad = 0; ifft_bad = 0;
        gap_in = 0; gap_out = 0; calc_cnt = 0; sum_ig = 0; sum_og = 0;
        e_ifft = 0; e_filt = 0; active = 0; after_done = 0; fin = 0; first = 1;
        req_valid = pend; req_ifft = v.ifft; req_filt = v.filt;
        in_empty = 0; out_full = 0; calc_done = 0;

        while (!fin && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                g = req_ready[1] ? 1 : 0;
                check("ready_onehot", $countones(req_ready), 1);
                check("grant_while_busy", busy, 0);
                check("grant_ch", g, model_pick(req_valid, model_ptr));
                if (first) check("first_grant", g, v.exp_first);
                first = 0;
                model_ptr = (g + 1) % N_CH;
                active = 1; g_cyc = cyc; cur_ch = g;
                e_ifft = v.ifft[g]; e_filt = v.filt[g];
                pops = 0; pushes = 0; filts = 0; addr_bad = 0; ifft_bad = 0;
                gap_in = 0; gap_out = 0; calc_cnt = 0; sum_ig = 0; sum_og = 0;
                for (int k = 0; k <= DEPTH; k++) begin
                    ig[k] = 0;
                    og[k] = 0;
                end
                for (int k = 1; k < DEPTH; k++) begin
                    if (v.in_mode == 1) ig[k] = 1;
                    if (v.in_mode == 2) ig[k] = $urandom_range(0, 4);
                    if (v.out_mode == 2) og[k] = $urandom_range(0, 4);
                    sum_ig += ig[k];
                end
                if (v.out_mode == 1) og[4] = 3;
                for (int k = 1; k < DEPTH; k++) sum_og += og[k];
                if (!v.cont) pend[g] = 1'b0;
            end else if (active) begin
                if (is_ifft !== e_ifft) ifft_bad++;
                if (in_pop) begin
                    if (ram_addr != ADDR_W'(pops)) addr_bad++;
                    pops++;
                    gap_in = (pops < DEPTH) ? ig[pops] : 0;
                end
                if (write_filter) begin
                    if (ram_addr != ADDR_W'(filts)) addr_bad++;
                    filts++;
                end
                if (out_push) begin
                    if (ram_addr != ADDR_W'(pushes)) addr_bad++;
                    pushes++;
                    gap_out = (pushes < DEPTH) ? og[pushes] : 0;
                end
                if (calc_start) calc_cnt = v.lat;
                if (done_valid) begin
                    exp_filt = (!v.exp_err && e_filt) ? DEPTH : 0;
                    exp_push = v.exp_err ? 0 : DEPTH;
                    if (v.exp_err)
                        exp_len = DEPTH + sum_ig + 1 + TMO + 1;
                    else
                        exp_len = DEPTH + sum_ig + 1 + v.lat + exp_filt + DEPTH + sum_og + 1;
                    check("done_ch", done_ch, cur_ch);
                    check("done_err", done_err, v.exp_err);
                    check("pop_count", pops, DEPTH);
                    check("filter_count", filts, exp_filt);
                    check("push_count", pushes, exp_push);
                    check("addr_order_errs", addr_bad, 0);
                    check("is_ifft_errs", ifft_bad, 0);
                    check("grant_to_done", cyc - g_cyc, exp_len);
                    jobs_done++;
                    active = 0;
                    if (jobs_done == v.n_jobs) after_done = 1;
                end
                if (abort_at > 0 && pushes == abort_at) begin
                    #1 rst = 1'b1;
                    req_valid = '0; in_empty = 0; out_full = 0; calc_done = 0;
                    #1 check("reset_async_outputs", out_vec, 0);
                    repeat (3) @(posedge clk);
                    #1 rst = 1'b0;
                    model_ptr = 0;
                    stray = 0;
                    repeat (6) begin
                        @(negedge clk);
                        if (done_valid || busy) stray++;
                    end
                    check("quiet_after_reset", stray, 0);
                    @(posedge clk);
                    #1;
                    fin = 1;
                    break;
                end
            end else if (after_done) begin
                check("idle_after_done", busy, 0);
                fin = 1;
            end

            @(posedge clk);
            #1;
            if (jobs_done == v.n_jobs) pend = '0;
            req_valid = pend;
            if (gap_in > 0) begin
                in_empty = 1;
                gap_in--;
            end else begin
                in_empty = 0;
            end
            if (gap_out > 0) begin
                out_full = 1;
                gap_out--;
            end else begin
                out_full = 0;
            end
            if (calc_cnt > 0) begin
                calc_cnt--;
                calc_done = (calc_cnt == 0);
            end else begin
                calc_done = (v.noise && active && pops < DEPTH) ? 1'($urandom % 2) : 1'b0;
            end
        end
        check("session_end", fin, 1);
        req_valid = '0; in_empty = 0; out_full = 0; calc_done = 0;
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        rst = 1'b1;
        req_valid = '0; req_ifft = '0; req_filt = '0;
        in_empty = 0; out_full = 0; calc_done = 0;

        tbl[0] = '{2'b01, 1'b0, 2'b00, 2'b00, 5, 0, 0, 1'b0, 1, 0, 1'b0};
        tbl[1] = '{2'b10, 1'b0, 2'b10, 2'b10, 3, 0, 0, 1'b0, 1, 1, 1'b0};
        tbl[2] = '{2'b11, 1'b1, 2'b01, 2'b10, 2, 0, 0, 1'b0, 4, 0, 1'b0};
        tbl[3] = '{2'b01, 1'b0, 2'b00, 2'b01, 4, 1, 1, 1'b1, 1, 0, 1'b0};
        tbl[4] = '{2'b10, 1'b0, 2'b10, 2'b00, 0, 0, 0, 1'b0, 1, 1, 1'b1};

        repeat (2) @(posedge clk);
        #1 check("reset_outputs", out_vec, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_session(tbl[i], 0);

        for (int i = 0; i < 8; i++) begin
            rv.mask     = 2'($urandom_range(1, 3));
            rv.cont     = 1'($urandom % 2);
            rv.ifft     = 2'($urandom % 4);
            rv.filt     = 2'($urandom % 4);
            rv.lat      = $urandom_range(1, 8);
            rv.in_mode  = 2;
            rv.out_mode = 2;
            rv.noise    = 1'($urandom % 2);
            rv.n_jobs   = rv.cont ? $urandom_range(2, 3) : $countones(rv.mask);
            rv.exp_first = model_pick(rv.mask, model_ptr);
            rv.exp_err  = 1'b0;
            run_session(rv, 0);
        end

        rv = '{2'b01, 1'b0, 2'b01, 2'b00, 2, 0, 0, 1'b0, 1, 0, 1'b0};
        run_session(rv, 3);
        rv = '{2'b11, 1'b0, 2'b00, 2'b00, 3, 0, 0, 1'b0, 2, 0, 1'b0};
        run_session(rv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
